// File: rtl/toggle_mon_pkg.sv
// Shared definitions for the toggle activity monitor: FSM state encoding
// and the default counter/window widths.
package toggle_mon_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int WIN_W_DEF = 16;

    // State encoding is kept as plain constants so older blocks that match on raw codes still line up.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/toggle_activity_monitor_if.sv
// Control/result bundle between a measurement controller (master) and the
// toggle activity monitor (slave).
interface toggle_activity_monitor_if
    import toggle_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) ();

    logic             start;
    logic [WIN_W-1:0] win_len;
    logic             sig_in;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] rise_cnt;
    logic [CNT_W-1:0] fall_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic             sat;

    modport master (
        output start, win_len, sig_in,
        input  busy, done, rise_cnt, fall_cnt, high_cnt, sat
    );

    modport slave (
        input  start, win_len, sig_in,
        output busy, done, rise_cnt, fall_cnt, high_cnt, sat
    );

endinterface

// File: rtl/toggle_edge_det.sv
// Sample path of the monitor: optional two-flop synchronizer, the reference
// level (prev) and the per-cycle rise/fall strobes.
// Build option: TOGGLE_MON_SYNC_EN inserts the synchronizer on sig_in.
module toggle_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    input  logic load,      // accepted start: capture reference level
    input  logic sample,    // RUN cycle: evaluate edge and update reference
    output logic sig_s,
    output logic rise,
    output logic fall
);

    logic prev_reg;

`ifdef TOGGLE_MON_SYNC_EN
    logic [1:0] sync_reg;

    // Two-flop synchronizer for a sig_in that is asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], sig_in};
        end
    end

    assign sig_s = sync_reg[1];
`else
    assign sig_s = sig_in;
`endif

    // Reference level: set on start (no edge counted then), tracked every RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg <= 1'b0;
        end else if (load || sample) begin
            prev_reg <= sig_s;
        end
    end

    assign rise = sample &&  sig_s && !prev_reg;
    assign fall = sample && !sig_s &&  prev_reg;

endmodule

// File: rtl/toggle_activity_monitor.sv
// Toggle activity monitor: counts rising edges, falling edges and high cycles
// of sig_in over a programmed window and holds the results until the next start.
// Build option: TOGGLE_MON_SYNC_EN (see toggle_edge_det).
module toggle_activity_monitor
    import toggle_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    toggle_activity_monitor_if.slave   bus
);

    state_t           state_reg;
    logic [WIN_W-1:0] remaining_reg;
    logic             done_reg;
    logic             sat_reg;
    logic [CNT_W-1:0] cnt_reg [3];   // 0: rise, 1: fall, 2: high

    logic       start_acc;
    logic       sampling;
    logic       sig_s;
    logic       rise;
    logic       fall;
    logic [2:0] inc;

    assign start_acc = bus.start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign sampling  = (state_reg == ST_RUN);
    assign inc       = {sampling && sig_s, fall, rise};

    toggle_edge_det u_edge_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (bus.sig_in),
        .load   (start_acc),
        .sample (sampling),
        .sig_s  (sig_s),
        .rise   (rise),
        .fall   (fall)
    );

    // Window FSM. A zero-length window enters DONE on the start edge but raises
    // done one cycle later, so done always trails the start by at least one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            done_reg      <= 1'b0;
        end else if (start_acc) begin
            state_reg     <= (bus.win_len == '0) ? ST_DONE : ST_RUN;
            remaining_reg <= bus.win_len;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    remaining_reg <= remaining_reg - WIN_W'(1);
                    if (remaining_reg == WIN_W'(1)) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end
                end
                ST_DONE: done_reg  <= 1'b1;
                ST_IDLE: ;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Saturating activity counters and the sticky overflow-attempt flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) cnt_reg[i] <= '0;
            sat_reg <= 1'b0;
        end else if (start_acc) begin
            for (int i = 0; i < 3; i++) cnt_reg[i] <= '0;
            sat_reg <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (inc[i]) begin
                    if (cnt_reg[i] == '1) begin
                        sat_reg <= 1'b1;
                    end else begin
                        cnt_reg[i] <= cnt_reg[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign bus.busy     = sampling;
    assign bus.done     = done_reg;
    assign bus.rise_cnt = cnt_reg[0];
    assign bus.fall_cnt = cnt_reg[1];
    assign bus.high_cnt = cnt_reg[2];
    assign bus.sat      = sat_reg;

endmodule
